// File: rtl/simt_scheduler.sv
// Per-core SIMT control FSM: per-thread PC/done tracking with min-PC group issue and reconvergence.
// Optional perf counters (cyc_cnt, issue_cnt, div_cnt) are compiled in when SIMT_SCHED_PERF_EN is defined.
module simt_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]           thread_count,
    output logic                                         fetch_req,
    input  logic                                         fetch_done,
    input  logic                                         decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]                 lsu_busy,
    input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0]   next_pc,
    output logic [PC_WIDTH-1:0]                          current_pc,
    output logic [THREADS_PER_BLOCK-1:0]                 active_mask,
    output logic [2:0]                                   core_state,
    output logic                                         done
`ifdef SIMT_SCHED_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]                         cyc_cnt,
    output logic [CNT_WIDTH-1:0]                         issue_cnt,
    output logic [CNT_WIDTH-1:0]                         div_cnt
`endif
);

    localparam int T    = THREADS_PER_BLOCK;
    localparam int TCNT = $clog2(THREADS_PER_BLOCK) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXEC    = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                     state;
    logic [T-1:0][PC_WIDTH-1:0] thread_pc;
    logic [T-1:0]               thread_done;
    logic [T-1:0]               done_init;
    logic [T-1:0]               done_after;
    logic [PC_WIDTH-1:0]        min_pc;
    logic [T-1:0]               group_mask;
    logic                       found;

    // Issuing group: unfinished threads sitting at the lowest PC.
    always_comb begin
        found  = 1'b0;
        min_pc = '0;
        for (int i = 0; i < T; i++) begin
            if (!thread_done[i] && (!found || thread_pc[i] < min_pc)) begin
                min_pc = thread_pc[i];
                found  = 1'b1;
            end
        end
        group_mask = '0;
        for (int i = 0; i < T; i++) begin
            if (!thread_done[i] && thread_pc[i] == min_pc)
                group_mask[i] = 1'b1;
        end
    end

    always_comb begin
        done_init = '0;
        for (int i = 0; i < T; i++)
            done_init[i] = (TCNT'(i) >= thread_count);
        done_after = thread_done | (decoded_ret ? group_mask : '0);
    end

    assign current_pc  = min_pc;
    assign active_mask = group_mask;
    assign core_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            thread_pc   <= '0;
            thread_done <= '1;
            done        <= 1'b0;
            fetch_req   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        thread_pc   <= '0;
                        thread_done <= done_init;
                        if (thread_count == '0) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_FETCH;
                            fetch_req <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (fetch_done) begin
                        state     <= S_DECODE;
                        fetch_req <= 1'b0;
                    end
                end
                S_DECODE:  state <= S_REQUEST;
                S_REQUEST: state <= S_WAIT;
                S_WAIT: begin
                    if (!(|(lsu_busy & group_mask)))
                        state <= S_EXEC;
                end
                S_EXEC:    state <= S_UPDATE;
                S_UPDATE: begin
                    for (int i = 0; i < T; i++) begin
                        if (group_mask[i] && !decoded_ret)
                            thread_pc[i] <= next_pc[i];
                    end
                    thread_done <= done_after;
                    if (&done_after) begin
                        state <= S_DONE;
                    end else begin
                        state     <= S_FETCH;
                        fetch_req <= 1'b1;
                    end
                end
                S_DONE:    done <= 1'b1;
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef SIMT_SCHED_PERF_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic multi_pc;

    always_comb begin
        multi_pc = 1'b0;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                if (group_mask[i] && group_mask[j] && next_pc[i] != next_pc[j])
                    multi_pc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt   <= '0;
            issue_cnt <= '0;
            div_cnt   <= '0;
        end else if (state == S_IDLE && start) begin
            cyc_cnt   <= '0;
            issue_cnt <= '0;
            div_cnt   <= '0;
        end else begin
            if (state != S_IDLE && state != S_DONE)
                cyc_cnt <= sat_inc(cyc_cnt);
            if (state == S_UPDATE) begin
                issue_cnt <= sat_inc(issue_cnt);
                if (!decoded_ret && multi_pc)
                    div_cnt <= sat_inc(div_cnt);
            end
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
